prime_count_ctrl: RTL and testbench

Command-driven controller that sequences the 3-bit prime counter datapath through 2 → 3 → 5 → 7 → 2. A requester issues CLEAR, STEP, RUN-for-N or STOP commands over a valid/ready handshake. The block owns the count register, reports busy/done status and flags wrap-around. It replaces the free-running prime counter wherever the step rate must be scheduled rather than tied to every clock.

---
 rtl/prime_ctrl_pkg.sv | 23 ++
 rtl/prime_next.sv | 30 +++
 rtl/prime_count_ctrl.sv | 128 ++++++++++++
 tb/tb_prime_count_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/prime_ctrl_pkg.sv
// Shared definitions for the command-driven prime counter controller:
// command encodings, controller states and the legal prime values.
package prime_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_STEP  = 2'b01,
        OP_RUN   = 2'b10,
        OP_STOP  = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [2:0] P2 = 3'd2;
    localparam logic [2:0] P3 = 3'd3;
    localparam logic [2:0] P5 = 3'd5;
    localparam logic [2:0] P7 = 3'd7;
    localparam logic [2:0] PRIME_RESET = P2;

endpackage

// File: rtl/prime_next.sv
// Combinational successor function for the 3-bit prime sequence
// 2 -> 3 -> 5 -> 7 -> 2. Any non-prime value recovers to 2 without a wrap.
module prime_next
    import prime_ctrl_pkg::*;
(
    input  logic [2:0] cur,
    output logic [2:0] nxt,
    output logic       is_wrap
);

    // Map each prime to its successor; only the 7 -> 2 step counts as a wrap.
    always_comb begin
        nxt     = PRIME_RESET;
        is_wrap = 1'b0;
        case (cur)
            P2: nxt = P3;
            P3: nxt = P5;
            P5: nxt = P7;
            P7: begin
                nxt     = P2;
                is_wrap = 1'b1;
            end
            default: begin
                nxt     = PRIME_RESET;
                is_wrap = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/prime_count_ctrl.sv
// Command-driven prime counter controller. Accepts CLEAR / STEP / RUN / STOP
// over a valid/ready handshake, owns the count register and reports busy,
// a one-cycle done pulse on completion and a one-cycle wrap pulse after 7 -> 2.
module prime_count_ctrl
    import prime_ctrl_pkg::*;
#(
    parameter int LEN_W = 4
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [LEN_W-1:0] cmd_len,
    output logic [2:0]       count,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    state_e           state_q, state_d;
    logic [2:0]       count_q, count_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic             done_q, done_d;
    logic             wrap_q, wrap_d;

    op_e              op;
    logic             accept;
    logic             advance;
    logic [2:0]       next_prime;
    logic             next_is_wrap;

    prime_next u_prime_next (
        .cur     (count_q),
        .nxt     (next_prime),
        .is_wrap (next_is_wrap)
    );

    assign op        = op_e'(cmd_op);
    assign cmd_ready = (state_q == ST_IDLE) || ((state_q == ST_RUN) && (op == OP_STOP));
    assign accept    = cmd_valid && cmd_ready;

    // Next-state logic: command decode in IDLE, stepping and STOP handling in RUN.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        wrap_d      = 1'b0;
        advance     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_CLEAR: begin
                            count_d = PRIME_RESET;
                            done_d  = 1'b1;
                        end
                        OP_STEP: begin
                            advance = 1'b1;
                            done_d  = 1'b1;
                        end
                        OP_RUN: begin
                            remaining_d = cmd_len;
                            state_d     = ST_RUN;
                        end
                        OP_STOP: begin
                            done_d = 1'b1;
                        end
                        default: begin
                            done_d = 1'b0;
                        end
                    endcase
                end
            end
            ST_RUN: begin
                if (accept) begin
                    state_d     = ST_IDLE;
                    done_d      = 1'b1;
                    remaining_d = '0;
                end else begin
                    advance = 1'b1;
                    if (remaining_q != '0) begin
                        remaining_d = remaining_q - LEN_W'(1);
                        if (remaining_q == LEN_W'(1)) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                remaining_d = '0;
            end
        endcase

        if (advance) begin
            count_d = next_prime;
            wrap_d  = next_is_wrap;
        end
    end

    // State, count, step budget and pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= PRIME_RESET;
            remaining_q <= '0;
            done_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
            wrap_q      <= wrap_d;
        end
    end

    assign count = count_q;
    assign busy  = (state_q == ST_RUN);
    assign done  = done_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_prime_count_ctrl.sv
// Self-checking bench for prime_count_ctrl: a table of per-cycle vectors for
// STEP / RUN / CLEAR sequences, plus hand-written free-run STOP and reset cases.
module tb_prime_count_ctrl;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_len;
    logic [2:0] count;
    logic       busy;
    logic       done;
    logic       wrap;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       valid;
        logic [1:0] op;
        logic [3:0] len;
        logic       exp_ready;
        logic [2:0] exp_count;
        logic       exp_busy;
        logic       exp_done;
        logic       exp_wrap;
    } vec_t;

    vec_t vecs[16];

    prime_count_ctrl #(.LEN_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [3:0] len);
        cmd_valid = v;
        cmd_op    = op;
        cmd_len   = len;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkRegs(input string tag, input int c, input int b, input int d, input int w);
        checkOutput({tag, "_count"}, int'(count), c);
        checkOutput({tag, "_busy"},  int'(busy),  b);
        checkOutput({tag, "_done"},  int'(done),  d);
        checkOutput({tag, "_wrap"},  int'(wrap),  w);
    endtask

    // Directed sequence: reset, table vectors, free-run STOP, reset mid-run.
    initial begin
        logic [2:0] fr_exp [9];
        string      tag;

        // valid, op, len, ready, count, busy, done, wrap
        vecs[0]  = '{1'b1, 2'b01, 4'd0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 2'b01, 4'd0, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 2'b01, 4'd0, 1'b1, 3'd7, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 2'b01, 4'd0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, 2'b10, 4'd6, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 2'b01, 4'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 2'b01, 4'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 2'b01, 4'd0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 2'b01, 4'd0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 2'b01, 4'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 2'b01, 4'd0, 1'b0, 3'd5, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 2'b01, 4'd0, 1'b1, 3'd7, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 2'b00, 4'd0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 2'b01, 4'd0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 2'b00, 4'd0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 2'b11, 4'd0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0};

        fr_exp = '{3'd5, 3'd7, 3'd2, 3'd3, 3'd5, 3'd7, 3'd2, 3'd3, 3'd5};

        reset = 1'b1;
        applyStimulus(1'b0, 2'b00, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkRegs("reset", 2, 0, 0, 0);
        checkOutput("reset_ready", int'(cmd_ready), 1);

        // Table vectors: ready checked before the edge, registers after it.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].op, vecs[i].len);
            #1;
            tag = $sformatf("vec%0d", i);
            checkOutput({tag, "_ready"}, int'(cmd_ready), int'(vecs[i].exp_ready));
            tick();
            checkRegs(tag, int'(vecs[i].exp_count), int'(vecs[i].exp_busy),
                      int'(vecs[i].exp_done), int'(vecs[i].exp_wrap));
        end

        // Free-run from 3, STOP presented in the 10th busy cycle.
        applyStimulus(1'b1, 2'b10, 4'd0);
        tick();
        checkRegs("fr_accept", 3, 1, 0, 0);
        applyStimulus(1'b0, 2'b01, 4'd0);
        for (int k = 0; k < 9; k++) begin
            tick();
            tag = $sformatf("fr_adv%0d", k + 1);
            checkRegs(tag, int'(fr_exp[k]), 1, 0, (fr_exp[k] == 3'd2) ? 1 : 0);
        end
        applyStimulus(1'b1, 2'b11, 4'd0);
        #1;
        checkOutput("fr_stop_ready", int'(cmd_ready), 1);
        tick();
        checkRegs("fr_stop", 5, 0, 1, 0);
        applyStimulus(1'b0, 2'b00, 4'd0);
        tick();
        checkRegs("fr_hold", 5, 0, 0, 0);

        // RUN L=8 from 5, reset asserted in the 3rd busy cycle.
        applyStimulus(1'b1, 2'b10, 4'd8);
        tick();
        checkRegs("rr_accept", 5, 1, 0, 0);
        applyStimulus(1'b0, 2'b00, 4'd0);
        tick();
        checkRegs("rr_adv1", 7, 1, 0, 0);
        tick();
        checkRegs("rr_adv2", 2, 1, 0, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkRegs("rr_reset", 2, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            tick();
            checkOutput($sformatf("rr_nodone%0d", k), int'(done), 0);
            checkOutput($sformatf("rr_hold%0d", k), int'(count), 2);
        end

        // Reset wins over a simultaneous STEP in IDLE.
        applyStimulus(1'b1, 2'b01, 4'd0);
        tick();
        checkRegs("pre_step", 3, 0, 1, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkRegs("rst_prio", 2, 0, 0, 0);
        applyStimulus(1'b0, 2'b00, 4'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
